// File: rtl/bv4_inv_pipe.sv
// Three-stage valid/ready GF(2^4) inverter over the GF(2^4)/GF(2^2) normal basis.
// Computes a^-1 = a^4 * (a1*a0 + (a1+a0)^2*SIGMA)^-1, with per-stage bubble collapse.
module bv4_inv_pipe #(
    parameter logic [1:0] SIGMA = 2'b10
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_b
);

    function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    // Squaring and inversion in GF(2^2) normal basis are the same bit swap.
    function automatic logic [1:0] gf4_sq(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    logic       r_v1, r_v2, r_v3;
    logic [3:0] r_s1_conj, r_s2_conj, r_s3_b;
    logic [1:0] r_s1_n, r_s2_t;

    logic       w_s1_ld, w_s2_ld, w_s3_ld;
    logic [1:0] w_n;

    // Load permissions resolve from the output end so a stage behind a bubble still advances.
    assign w_s3_ld = !r_v3 || out_ready;
    assign w_s2_ld = !r_v2 || w_s3_ld;
    assign w_s1_ld = !r_v1 || w_s2_ld;

    assign w_n = gf4_mul(in_a[3:2], in_a[1:0])
               ^ gf4_mul(gf4_sq(in_a[3:2] ^ in_a[1:0]), SIGMA);

    assign in_ready  = w_s1_ld;
    assign out_valid = r_v3;
    assign out_b     = r_s3_b;

    always_ff @(posedge in_clock) begin
        if (in_reset || in_flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_s1_ld) r_v1 <= in_valid;
            if (w_s2_ld) r_v2 <= r_v1;
            if (w_s3_ld) r_v3 <= r_v2;
        end
    end

    // NOTE: data registers have no reset; the valid bits alone decide whether their contents matter.
    always_ff @(posedge in_clock) begin
        if (w_s1_ld && in_valid) begin
            r_s1_conj <= {in_a[1:0], in_a[3:2]};
            r_s1_n    <= w_n;
        end
        if (w_s2_ld && r_v1) begin
            r_s2_conj <= r_s1_conj;
            r_s2_t    <= gf4_sq(r_s1_n);
        end
        if (w_s3_ld && r_v2) begin
            r_s3_b <= {gf4_mul(r_s2_conj[3:2], r_s2_t), gf4_mul(r_s2_conj[1:0], r_s2_t)};
        end
    end

endmodule

// File: tb/tb_bv4_inv_pipe.sv
// Scoreboard bench for bv4_inv_pipe: expected inverses come from a brute-force
// search over a normal-basis GF(2^4) multiplier model.
module tb_bv4_inv_pipe;

    localparam logic [1:0] SIGMA = 2'b10;

    logic       clk = 1'b0;
    logic       in_reset, in_flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_a, out_b;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  n_out    = 0;

    bv4_inv_pipe #(.SIGMA(SIGMA)) dut (
        .in_clock (clk),
        .in_reset (in_reset),
        .in_flush (in_flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_b    (out_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_mul2(input logic [1:0] x, input logic [1:0] y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    // Full GF(2^4) product in the normal basis; the unit element is 4'hF.
    function automatic logic [3:0] m_mul4(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] e;
        e = m_mul2(m_mul2(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]), SIGMA);
        return {m_mul2(a[3:2], b[3:2]) ^ e, m_mul2(a[1:0], b[1:0]) ^ e};
    endfunction

    function automatic logic [3:0] m_inv(input logic [3:0] a);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 1; i < 16; i++) begin
            if (m_mul4(a, 4'(i)) == 4'hF) r = 4'(i);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (in_reset || in_flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("out_b", 32'(out_b), 32'(e.b));
                    if (e.a != 4'h0) check("a_times_inv", 32'(m_mul4(e.a, out_b)), 32'hF);
                    check("inv_inv", 32'(m_inv(out_b)), 32'(e.a));
                end
                n_out++;
            end
            if (in_valid && in_ready) sb_q.push_back('{a: in_a, b: m_inv(in_a)});
        end
    end

    task automatic single_op(input logic [3:0] a, input logic [3:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        look();
        check("single_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        look();
        check("single_early", 32'(out_valid), 32'd0);
        tick();
        look();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_value", 32'(out_b), 32'(exp));
        tick();
        look();
        check("single_gone", 32'(out_valid), 32'd0);
        tick();
    endtask

    logic [3:0] bp_ops[6] = '{4'h2, 4'h7, 4'hB, 4'hE, 4'h5, 4'h9};
    logic [3:0] dir_a[4]  = '{4'hF, 4'h0, 4'hC, 4'h1};
    logic [3:0] dir_b[4]  = '{4'hF, 4'h0, 4'h1, 4'hC};

    initial begin
        in_reset  = 1'b1;
        in_flush  = 1'b0;
        in_valid  = 1'b0;
        in_a      = 4'h0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_reset = 1'b0;
        look();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        tick();

        for (int i = 0; i < 4; i++) single_op(dir_a[i], dir_b[i]);

        // Back-to-back stream of every operand; results in cycles 3..18.
        begin
            int base;
            base = n_out;
            for (int c = 0; c < 20; c++) begin
                in_valid = (c < 16);
                in_a     = 4'(c);
                look();
                if (c < 16) check("stream_ready", 32'(in_ready), 32'd1);
                check("stream_out_valid", 32'(out_valid), 32'(c >= 3 && c <= 18));
                tick();
            end
            check("stream_count", 32'(n_out - base), 32'd16);
        end

        // Backpressure: out_ready low in cycles 4..9 with the pipe full.
        begin
            int         base, sent;
            logic [3:0] held;
            base = n_out;
            sent = 0;
            held = 4'h0;
            for (int c = 0; c < 22; c++) begin
                out_ready = !(c >= 4 && c <= 9);
                in_valid  = (sent < 6);
                if (sent < 6) in_a = bp_ops[sent];
                look();
                if (c == 4) held = out_b;
                if (c >= 4 && c <= 9) begin
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                    check("bp_out_valid", 32'(out_valid), 32'd1);
                    check("bp_hold", 32'(out_b), 32'(held));
                end
                if (c == 10) check("bp_full_transfer_ready", 32'(in_ready), 32'd1);
                if (in_valid && in_ready) sent++;
                tick();
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("bp_sent", 32'(sent), 32'd6);
            check("bp_count", 32'(n_out - base), 32'd6);
        end

        // Bubble collapse with out_ready held low.
        begin
            int base;
            base      = n_out;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_a      = 4'h3;
            tick();
            in_valid = 1'b0;
            tick();
            in_valid = 1'b1;
            in_a     = 4'hA;
            look();
            check("bubble_ready_c2", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            look();
            check("bubble_ready_c3", 32'(in_ready), 32'd1);
            check("bubble_out_valid", 32'(out_valid), 32'd1);
            tick();
            look();
            check("bubble_ready_c4", 32'(in_ready), 32'd1);
            check("bubble_head", 32'(out_b), 32'(m_inv(4'h3)));
            tick();
            out_ready = 1'b1;
            repeat (4) tick();
            check("bubble_count", 32'(n_out - base), 32'd2);
        end

        // Flush with three operands in flight and a new operand offered.
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_a     = 4'(5 + c);
            tick();
        end
        in_a     = 4'h9;
        in_flush = 1'b1;
        look();
        check("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_flush = 1'b0;
        in_valid = 1'b0;
        look();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready_after", 32'(in_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            look();
            check("flush_no_stale", 32'(out_valid), 32'd0);
        end
        tick();
        single_op(4'hC, 4'h1);

        // Reset while stalled full; second pass also raises flush.
        for (int k = 0; k < 2; k++) begin
            out_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
                in_valid = 1'b1;
                in_a     = 4'(8 + c);
                tick();
            end
            in_a     = 4'hD;
            look();
            check("rst_full_in_ready", 32'(in_ready), 32'd0);
            check("rst_full_out_valid", 32'(out_valid), 32'd1);
            in_reset = 1'b1;
            in_flush = (k == 1);
            tick();
            in_reset  = 1'b0;
            in_flush  = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            look();
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            for (int c = 0; c < 4; c++) begin
                tick();
                look();
                check("rst_no_stale", 32'(out_valid), 32'd0);
            end
            tick();
        end

        repeat (3) tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
